// File: rtl/pulse_conditioner_pkg.sv
// Shared state encodings for the pulse conditioner and the downstream pulse-counting FSM.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: none.
package fsm_pkg;

    // Debouncer states. Bit 1 is the accepted level; bit 0 marks a pending check.
    typedef enum logic [1:0] {
        LOW      = 2'b00,
        CHK_HIGH = 2'b01,
        HIGH     = 2'b10,
        CHK_LOW  = 2'b11
    } pc_state_t;

    // Downstream counter FSM states, advanced once per conditioned pulse.
    typedef enum logic [1:0] {
        CNT_S0 = 2'b00,
        CNT_S1 = 2'b01,
        CNT_S2 = 2'b10,
        CNT_S3 = 2'b11
    } cnt_state_t;

    // The debounce counter never needs to hold more than DEBOUNCE_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic logic state_level(input pc_state_t s);
        return (s == HIGH) || (s == CHK_LOW);
    endfunction

    function automatic logic state_busy(input pc_state_t s);
        return (s == CHK_HIGH) || (s == CHK_LOW);
    endfunction

endpackage

// File: rtl/pulse_conditioner_if.sv
// Bundles the raw input and the conditioned outputs of the pulse conditioner.
// Latency: none (wiring only).
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
interface pulse_conditioner_if;
    logic raw_in;
    logic level_out;
    logic pulse_out;
    logic busy;

    modport master (
        output raw_in,
        input  level_out,
        input  pulse_out,
        input  busy
    );

    modport slave (
        input  raw_in,
        output level_out,
        output pulse_out,
        output busy
    );
endinterface

// File: rtl/pulse_conditioner_sync_ff.sv
// Multi-stage single-bit synchroniser for asynchronous external inputs.
// Latency: STAGES clock edges from d to q.
// Backpressure: none; samples every cycle.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the input through the flop chain; reset clears every stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_conditioner.sv
// Synchronises and debounces a bouncy input; one-cycle pulse per accepted rising edge.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from a stable raw change to level/pulse.
// Backpressure: none; a new pulse needs a full fall check and a full rise check first.
module pulse_conditioner
    import fsm_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_conditioner_if.slave    io
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic            sync_in;
    pc_state_t       state_q;
    pc_state_t       state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            pulse_d;
    logic            level_q;
    logic            pulse_q;
    logic            busy_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (io.raw_in),
        .q   (sync_in)
    );

    // Next state, counter and pulse: a change is accepted only after the
    // counter reaches its last value while the input still disagrees.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            LOW: begin
                if (sync_in) begin
                    state_d = CHK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHK_HIGH: begin
                if (!sync_in) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync_in) begin
                    state_d = CHK_LOW;
                    cnt_d   = '0;
                end
            end
            CHK_LOW: begin
                if (sync_in) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset discards any in-flight check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs decoded from the state being entered, so they track state_q exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            level_q <= state_level(state_d);
            pulse_q <= pulse_d;
            busy_q  <= state_busy(state_d);
        end
    end

    assign io.level_out = level_q;
    assign io.pulse_out = pulse_q;
    assign io.busy      = busy_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Self-checking bench: run-length reference model plus directed literal checkpoints.
// Latency: model predicts outputs after every rising edge.
// Backpressure: none.
module tb_pulse_conditioner;
    import fsm_pkg::*;

    localparam int S = 2;
    localparam int D = 4;

    logic clk;
    logic rst;

    pulse_conditioner_if pif ();

    pulse_conditioner #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (pif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int dut_pulses = 0;

    // Reference model: raw samples delayed S edges, then a change is accepted
    // once D+1 consecutive samples all disagree with the accepted level.
    logic [S-1:0] sh;
    int           run;
    logic         lvl_m;
    logic         pulse_m;
    logic         busy_m;

    task automatic chk(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sh      = '0;
        run     = 0;
        lvl_m   = 1'b0;
        pulse_m = 1'b0;
        busy_m  = 1'b0;
    endtask

    task automatic model_edge(input logic r);
        logic s;
        if (rst) begin
            s       = sh[S-1];
            pulse_m = 1'b0;
            if (s != lvl_m) begin
                run = run + 1;
                if (run == D + 1) begin
                    lvl_m   = s;
                    pulse_m = s;
                    run     = 0;
                end
            end else begin
                run = 0;
            end
            busy_m = (run > 0);
            sh     = {sh[S-2:0], r};
        end
    endtask

    // One clock: drive raw away from the edge, advance the model, compare after the edge.
    task automatic cycle(input logic r);
        pif.raw_in = r;
        @(posedge clk);
        model_edge(r);
        #1;
        chk("model_level", pif.level_out, lvl_m);
        chk("model_pulse", pif.pulse_out, pulse_m);
        chk("model_busy",  pif.busy,      busy_m);
        if (pif.pulse_out === 1'b1) dut_pulses++;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_level"}, pif.level_out, 1'b0);
        chk({name, "_pulse"}, pif.pulse_out, 1'b0);
        chk({name, "_busy"},  pif.busy,      1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int presses;
        logic ds_out;

        rst        = 1'b0;
        pif.raw_in = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held with a toggling input: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            cycle(logic'(i % 2 == 0));
            chk_zero("reset_hold");
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0);
            chk_zero("reset_release");
        end

        // Clean press: raw high before edge 0.
        p0 = dut_pulses;
        for (int e = 0; e < 10; e++) begin
            cycle(1'b1);
            if (e == 1) chk("press_busy_e1", pif.busy, 1'b0);
            if (e == 2) chk("press_busy_e2", pif.busy, 1'b1);
            if (e == 5) chk("press_level_e5", pif.level_out, 1'b0);
            if (e == 6) begin
                chk("press_level_e6", pif.level_out, 1'b1);
                chk("press_pulse_e6", pif.pulse_out, 1'b1);
                chk("press_busy_e6",  pif.busy,      1'b0);
            end
            if (e == 7) chk("press_pulse_e7", pif.pulse_out, 1'b0);
        end
        chk_int("press_pulse_count", dut_pulses - p0, 1);

        // Release bounce: two-cycle drop is rejected.
        p0 = dut_pulses;
        cycle(1'b0);
        cycle(1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            chk("relbounce_level", pif.level_out, 1'b1);
        end
        chk_int("relbounce_pulses", dut_pulses - p0, 0);

        // Sustained drop: level falls after edge 6, no pulse.
        p0 = dut_pulses;
        for (int e = 0; e < 10; e++) begin
            cycle(1'b0);
            if (e == 5) chk("fall_level_e5", pif.level_out, 1'b1);
            if (e == 6) chk("fall_level_e6", pif.level_out, 1'b0);
        end
        chk_int("fall_pulses", dut_pulses - p0, 0);

        // Bounce: high 3, low 1, high 2, then low.
        p0 = dut_pulses;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        cycle(1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0);
        chk_int("bounce_pulses", dut_pulses - p0, 0);
        chk_zero("bounce_end");

        // Four clean presses drive a 4-state counter; output high in its last state.
        p0      = dut_pulses;
        presses = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) cycle(1'b1);
            for (int i = 0; i < 8; i++) cycle(1'b0);
            presses = (dut_pulses - p0) % 4;
            ds_out  = (cnt_state_t'(presses) == CNT_S3);
            if (k == 2) chk("ds_high_after_3", ds_out, 1'b1);
            if (k == 3) chk("ds_low_after_4",  ds_out, 1'b0);
        end
        chk_int("ds_pulse_count", dut_pulses - p0, 4);

        // Mid-check reset: abort CHK_HIGH, then one pulse 6 edges after release.
        for (int i = 0; i < 4; i++) cycle(1'b1);
        chk("midrst_busy_before", pif.busy, 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        chk_zero("midrst_immediate");
        @(negedge clk);
        cycle(1'b1);
        cycle(1'b1);
        chk_zero("midrst_held");
        rst = 1'b1;
        p0  = dut_pulses;
        for (int e = 0; e < 14; e++) begin
            cycle(1'b1);
            if (e == 5) chk("midrst_pulse_e5", pif.pulse_out, 1'b0);
            if (e == 6) chk("midrst_pulse_e6", pif.pulse_out, 1'b1);
        end
        chk_int("midrst_pulse_count", dut_pulses - p0, 1);

        // Randomised runs with occasional resets, checked against the model every cycle.
        for (int k = 0; k < 500; k++) begin
            logic v;
            int   len;
            v   = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) cycle(v);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                chk_zero("rand_reset");
                @(negedge clk);
                cycle(logic'($urandom_range(0, 1)));
                rst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_conditioner.md
# pulse_conditioner

Upstream input stage for the pulse-counting Moore FSM. It takes an asynchronous, bouncy 1-bit input (button or external line) and synchronises it into `clk`. It debounces the synchronised value and emits a single-cycle `pulse_out` on each debounced rising edge. `pulse_out` drives the FSM's `in` port directly, so one physical press advances the FSM by exactly one state, not one state per clock held.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the input synchroniser; legal ≥ 2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required in a check state before a level change is accepted; legal ≥ 1.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `raw_in` in 1: asynchronous raw input.
- `level_out` out 1: debounced level.
- `pulse_out` out 1: one-cycle pulse on each accepted 0→1 change; feeds the FSM `in`.
- `busy` out 1: high while in a check state.

## Operation
- Synchroniser: `raw_in` passes through SYNC_STAGES flops. The last stage is `sync_in`. Nothing else samples `raw_in`.
- The FSM has four states:
  - LOW: `level_out` = 0.
  - CHK_HIGH: `level_out` = 0, `busy` = 1.
  - HIGH: `level_out` = 1.
  - CHK_LOW: `level_out` = 1, `busy` = 1.
- Transitions, evaluated each rising edge:
  - LOW: `sync_in` = 1 → CHK_HIGH, cnt ← 0. Otherwise stay.
  - CHK_HIGH:
    - `sync_in` = 0 → LOW, cnt ← 0; no pulse.
    - `sync_in` = 1 and cnt = DEBOUNCE_CYCLES−1 → HIGH, `pulse_out` ← 1.
    - Otherwise cnt ← cnt+1.
  - HIGH: `sync_in` = 0 → CHK_LOW, cnt ← 0. Otherwise stay.
  - CHK_LOW:
    - `sync_in` = 1 → HIGH, cnt ← 0.
    - `sync_in` = 0 and cnt = DEBOUNCE_CYCLES−1 → LOW.
    - Otherwise cnt ← cnt+1.
- `pulse_out` is registered. It is 1 only in the cycle immediately after the CHK_HIGH→HIGH edge and returns to 0 on the next edge. It is never asserted on a falling change.
- `level_out` and `busy` are registered, Moore-style, and decoded from state.
- Counter width is max(1, $clog2(DEBOUNCE_CYCLES)). It is compared against DEBOUNCE_CYCLES−1 only in check states, so it never wraps.
- Reset (`rst` = 0, any time, including mid-check):
  - Synchroniser flops, cnt, `level_out`, `pulse_out` and `busy` are all 0.
  - State is LOW.
  - An in-flight check is discarded and no pulse is emitted.
- If `raw_in` is already high at reset release, it is treated as a new rising change: normal debounce applies, then exactly one pulse.

## Timing
- Rise latency: `raw_in` stable high before edge 0 → `level_out` = 1 and `pulse_out` = 1 after edge SYNC_STAGES+DEBOUNCE_CYCLES. With the defaults this is edge 6, and `pulse_out` returns to 0 after edge 7.
- Fall latency: the same count of edges to `level_out` = 0, with no pulse.
- Minimum accepted high width at `sync_in` is DEBOUNCE_CYCLES+1 consecutive samples. Any shorter run produces no pulse and no level change.
- Back-to-back presses: after a pulse, a new pulse requires passing through CHK_LOW→LOW and then a full rise check. Minimum pulse spacing is 2·(DEBOUNCE_CYCLES+1) cycles.
- Reset assertion is asynchronous. Release is expected synchronous to `clk` upstream; the block adds no reset synchroniser.

## Structure
- Shared package `fsm_pkg` holds the state typedef as a 2-bit enum with LOW=00, CHK_HIGH=01, HIGH=10, CHK_LOW=11. The downstream counter FSM's state encodings also belong in this package.
- Sub-module `sync_ff`: a parameterised SYNC_STAGES-deep single-bit synchroniser with asynchronous active-low reset to 0. It is reused for other external inputs.
- Top level contains `sync_ff`, the counter and the FSM, with registered outputs.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with `raw_in` toggling → all outputs 0 throughout. Release with `raw_in` = 0 → outputs stay 0.
- Clean press (defaults): `raw_in` 0→1 before edge 0 and held → `busy` = 1 after edge 2, `level_out` = 1 and `pulse_out` = 1 after edge 6, `pulse_out` = 0 after edge 7, `busy` = 0 after edge 6.
- Bounce: `raw_in` high for 3 cycles, low 1, high 2, low → zero pulses, `level_out` stays 0, state returns to LOW.
- Release bounce: from HIGH, drop `raw_in` for 2 cycles then restore → `level_out` stays 1 and no second pulse. A sustained drop gives `level_out` = 0 six edges after the drop.
- Downstream count: four clean presses separated by ≥ 12 cycles, driving the FSM → exactly 4 `pulse_out` cycles; the FSM reaches its output-high state after the 3rd and returns after the 4th.
- Mid-check reset: assert `rst` while `busy` = 1 in CHK_HIGH → immediate clear and no pulse. With `raw_in` held high, exactly one pulse follows 6 edges after release.
